// File: rtl/mem_line_split.sv
// mem_line_split: turns one memory operand into one or two line-aligned
// requests for the memory/TLB stage.
//
// An operand is given as a start address and an inclusive end address. If
// both fall in the same line, one request is issued. If they fall in adjacent
// lines, two requests are issued, and line-address wrap from all-ones to zero
// counts as adjacent. If they span more than two lines, no request is issued
// and span_err pulses for one cycle. An rw code of 00 means the instruction
// does not use memory, so the operand is consumed and nothing else happens.
//
// Ports:
//   clk, clr             clock; synchronous active-high reset
//   in_valid/in_ready    operand handshake (in_ready = state is IDLE)
//   in_addr, in_addr_end first and last byte address of the access
//   in_rw, in_ptcid      rw code and instruction tag, passed through
//   req_valid/req_ready  line request handshake
//   req_line             line address (addr >> LINE_LOG2)
//   req_bytemask         bytes touched within the line
//   req_rw, req_ptcid    copies of the operand's rw code and tag
//   req_last             final request of the operand
//   req_split            operand spans two lines
//   span_err             one-cycle pulse: operand spans more than two lines
module mem_line_split #(
  parameter int LINE_LOG2 = 4,
  parameter int ID_WIDTH  = 7
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_addr,
  input  logic [31:0]               in_addr_end,
  input  logic [1:0]                in_rw,
  input  logic [ID_WIDTH-1:0]       in_ptcid,
  output logic                      req_valid,
  input  logic                      req_ready,
  output logic [31-LINE_LOG2:0]     req_line,
  output logic [(2**LINE_LOG2)-1:0] req_bytemask,
  output logic [1:0]                req_rw,
  output logic [ID_WIDTH-1:0]       req_ptcid,
  output logic                      req_last,
  output logic                      req_split,
  output logic                      span_err
);

  localparam int LW = 32 - LINE_LOG2;
  localparam int MW = 2 ** LINE_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ0 = 2'd1,
    REQ1 = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Mask with bits off..MW-1 set.
  function automatic logic [MW-1:0] lo_mask(input logic [LINE_LOG2-1:0] off);
    logic [MW-1:0] ones;
    ones = '1;
    return ones << off;
  endfunction

  // Mask with bits 0..off set.
  function automatic logic [MW-1:0] hi_mask(input logic [LINE_LOG2-1:0] off);
    logic [MW-1:0] ones;
    logic [LINE_LOG2-1:0] sh;
    ones = '1;
    sh   = ~off;
    return ones >> sh;
  endfunction

  logic                 accept;
  logic                 is_mem;
  logic [LW-1:0]        l0, l1, lines;
  logic [LINE_LOG2-1:0] so, eo;
  logic                 one_line, two_lines;

  // Second-request context captured when a split operand is accepted.
  logic [LW-1:0]        line1_q;
  logic [LINE_LOG2-1:0] eo_q;

  assign accept    = in_valid & in_ready;
  assign is_mem    = (in_rw != 2'b00);
  assign l0        = in_addr[31:LINE_LOG2];
  assign l1        = in_addr_end[31:LINE_LOG2];
  assign so        = in_addr[LINE_LOG2-1:0];
  assign eo        = in_addr_end[LINE_LOG2-1:0];
  // The subtraction wraps modulo 2**LW, so a start in the top line and an
  // end in line zero give a distance of one.
  assign lines     = l1 - l0;
  assign one_line  = (lines == '0);
  assign two_lines = (lines == LW'(1));

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept && is_mem && (one_line || two_lines)) state_nxt = REQ0;
      end
      REQ0: begin
        if (req_ready) state_nxt = req_last ? IDLE : REQ1;
      end
      REQ1: begin
        if (req_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    req_valid = (state == REQ0) || (state == REQ1);
  end

  // Request payload registers. They change only on accept and on the
  // REQ0 -> REQ1 step, so they hold still while downstream stalls.
  always_ff @(posedge clk) begin
    if (clr) begin
      req_line     <= '0;
      req_bytemask <= '0;
      req_rw       <= '0;
      req_ptcid    <= '0;
      req_last     <= 1'b0;
      req_split    <= 1'b0;
      span_err     <= 1'b0;
      line1_q      <= '0;
      eo_q         <= '0;
    end else begin
      span_err <= accept && is_mem && !one_line && !two_lines;
      if (state == IDLE) begin
        if (accept && is_mem && one_line) begin
          req_line     <= l0;
          req_bytemask <= lo_mask(so) & hi_mask(eo);
          req_rw       <= in_rw;
          req_ptcid    <= in_ptcid;
          req_last     <= 1'b1;
          req_split    <= 1'b0;
        end else if (accept && is_mem && two_lines) begin
          req_line     <= l0;
          req_bytemask <= lo_mask(so);
          req_rw       <= in_rw;
          req_ptcid    <= in_ptcid;
          req_last     <= 1'b0;
          req_split    <= 1'b1;
          line1_q      <= l1;
          eo_q         <= eo;
        end
      end else if (state == REQ0 && req_ready && !req_last) begin
        req_line     <= line1_q;
        req_bytemask <= hi_mask(eo_q);
        req_last     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_line_split.sv
module tb_mem_line_split;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_addr = '0;
  logic [31:0] in_addr_end = '0;
  logic [1:0]  in_rw = '0;
  logic [6:0]  in_ptcid = '0;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [27:0] req_line;
  logic [15:0] req_bytemask;
  logic [1:0]  req_rw;
  logic [6:0]  req_ptcid;
  logic        req_last;
  logic        req_split;
  logic        span_err;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [27:0] line;
    logic [15:0] mask;
    logic        last;
    logic        split;
    logic [1:0]  rw;
    logic [6:0]  id;
  } exp_t;

  exp_t sb[$];

  mem_line_split #(.LINE_LOG2(4), .ID_WIDTH(7)) dut (
    .clk(clk), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_addr_end(in_addr_end),
    .in_rw(in_rw), .in_ptcid(in_ptcid),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_line(req_line), .req_bytemask(req_bytemask),
    .req_rw(req_rw), .req_ptcid(req_ptcid),
    .req_last(req_last), .req_split(req_split),
    .span_err(span_err)
  );

  always #5 clk = ~clk;

  // Scoreboard: every request handshake pops one expected entry.
  always @(negedge clk) begin
    if (!clr && req_valid && req_ready) begin
      exp_t got, exp;
      got = {req_line, req_bytemask, req_last, req_split, req_rw, req_ptcid};
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_req: got line=%h mask=%h last=%b split=%b, required none",
                 req_line, req_bytemask, req_last, req_split);
      end else begin
        exp = sb.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL req_fields: got line=%h mask=%h last=%b split=%b rw=%b id=%h, required line=%h mask=%h last=%b split=%b rw=%b id=%h",
                   got.line, got.mask, got.last, got.split, got.rw, got.id,
                   exp.line, exp.mask, exp.last, exp.split, exp.rw, exp.id);
        end
      end
    end
  end

  // Present one operand; returns #1 after the accepting edge.
  task automatic send_op(input logic [31:0] a, input logic [31:0] e,
                         input logic [1:0] rw, input logic [6:0] id,
                         input bit rnd_ready);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      if (rnd_ready) req_ready = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      errors++; checks++;
      $display("FAIL send_timeout: in_ready=%b, required 1", in_ready);
    end
    in_addr = a; in_addr_end = e; in_rw = rw; in_ptcid = id; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Let outstanding requests retire, bounded.
  task automatic drain(input string name);
    int n;
    n = 0;
    req_ready = 1'b1;
    while ((sb.size() != 0 || !in_ready) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (sb.size() != 0 || !in_ready) begin
      errors++;
      $display("FAIL %s_drain: pending=%0d in_ready=%b, required 0 and 1", name, sb.size(), in_ready);
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    checks++;
    if ({req_valid, in_ready, span_err, req_last, req_split} !== 5'b01000) begin
      errors++;
      $display("FAIL reset_ctrl: valid=%b ready=%b err=%b last=%b split=%b, required 0 1 0 0 0",
               req_valid, in_ready, span_err, req_last, req_split);
    end
    checks++;
    if ({req_line, req_bytemask, req_rw, req_ptcid} !== '0) begin
      errors++;
      $display("FAIL reset_data: line=%h mask=%h rw=%b id=%h, required all zero",
               req_line, req_bytemask, req_rw, req_ptcid);
    end
  endtask

  task automatic test_aligned();
    req_ready = 1'b1;
    sb.push_back({28'h0000100, 16'h00F0, 1'b1, 1'b0, 2'b01, 7'h05});
    send_op(32'h00001004, 32'h00001007, 2'b01, 7'h05, 0);
    checks++;
    if (req_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL aligned_latency: valid=%b ready=%b, required 1 0", req_valid, in_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (req_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL aligned_idle: valid=%b ready=%b, required 0 1", req_valid, in_ready);
    end
    drain("aligned");
  endtask

  task automatic test_split();
    req_ready = 1'b1;
    sb.push_back({28'h0000200, 16'hF000, 1'b0, 1'b1, 2'b10, 7'h11});
    sb.push_back({28'h0000201, 16'h000F, 1'b1, 1'b1, 2'b10, 7'h11});
    send_op(32'h0000200C, 32'h00002013, 2'b10, 7'h11, 0);
    drain("split");
  endtask

  task automatic test_backpressure();
    req_ready = 1'b0;
    sb.push_back({28'h0000200, 16'hF000, 1'b0, 1'b1, 2'b10, 7'h33});
    sb.push_back({28'h0000201, 16'h000F, 1'b1, 1'b1, 2'b10, 7'h33});
    send_op(32'h0000200C, 32'h00002013, 2'b10, 7'h33, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({req_valid, in_ready, req_line, req_bytemask, req_last} !== {2'b10, 28'h0000200, 16'hF000, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold0: valid=%b ready=%b line=%h mask=%h last=%b, required 1 0 0000200 f000 0",
                 req_valid, in_ready, req_line, req_bytemask, req_last);
      end
      @(posedge clk); #1;
    end
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({req_valid, in_ready, req_line, req_bytemask, req_last} !== {2'b10, 28'h0000201, 16'h000F, 1'b1}) begin
        errors++;
        $display("FAIL bp_hold1: valid=%b ready=%b line=%h mask=%h last=%b, required 1 0 0000201 000f 1",
                 req_valid, in_ready, req_line, req_bytemask, req_last);
      end
      @(posedge clk); #1;
    end
    drain("bp");
  endtask

  task automatic test_nomem_err();
    req_ready = 1'b1;
    send_op(32'h00000040, 32'h00000043, 2'b00, 7'h01, 0);
    checks++;
    if ({req_valid, in_ready, span_err} !== 3'b010) begin
      errors++;
      $display("FAIL nomem: valid=%b ready=%b err=%b, required 0 1 0", req_valid, in_ready, span_err);
    end
    send_op(32'h00000100, 32'h0000012F, 2'b01, 7'h02, 0);
    checks++;
    if ({req_valid, in_ready, span_err} !== 3'b011) begin
      errors++;
      $display("FAIL span_err_pulse: valid=%b ready=%b err=%b, required 0 1 1", req_valid, in_ready, span_err);
    end
    @(posedge clk); #1;
    checks++;
    if ({req_valid, span_err} !== 2'b00) begin
      errors++;
      $display("FAIL span_err_clear: valid=%b err=%b, required 0 0", req_valid, span_err);
    end
    drain("nomem");
  endtask

  task automatic test_wrap();
    req_ready = 1'b1;
    sb.push_back({28'hFFFFFFF, 16'hC000, 1'b0, 1'b1, 2'b11, 7'h7F});
    sb.push_back({28'h0000000, 16'h0003, 1'b1, 1'b1, 2'b11, 7'h7F});
    send_op(32'hFFFFFFFE, 32'h00000001, 2'b11, 7'h7F, 0);
    drain("wrap");
  endtask

  task automatic test_reset_mid();
    req_ready = 1'b0;
    sb.push_back({28'h0000200, 16'hF000, 1'b0, 1'b1, 2'b10, 7'h22});
    send_op(32'h0000200C, 32'h00002013, 2'b10, 7'h22, 0);
    req_ready = 1'b1;
    @(posedge clk); #1;
    req_ready = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    checks++;
    if ({req_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL reset_mid: valid=%b ready=%b, required 0 1", req_valid, in_ready);
    end
    req_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0 || req_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_stale: pending=%0d valid=%b, required 0 0", sb.size(), req_valid);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 24; k++) begin
      logic [31:0] a, e;
      logic [1:0]  rw;
      logic [6:0]  id;
      logic [15:0] m0, m1;
      int so, eo;
      a  = $urandom;
      e  = a + 32'($urandom_range(0, 15));
      rw = 2'($urandom_range(1, 3));
      id = 7'($urandom);
      so = int'(a[3:0]);
      eo = int'(e[3:0]);
      m0 = '0; m1 = '0;
      if (a[31:4] == e[31:4]) begin
        for (int b = 0; b < 16; b++) if (b >= so && b <= eo) m0[b] = 1'b1;
        sb.push_back({a[31:4], m0, 1'b1, 1'b0, rw, id});
      end else begin
        for (int b = 0; b < 16; b++) begin
          if (b >= so) m0[b] = 1'b1;
          if (b <= eo) m1[b] = 1'b1;
        end
        sb.push_back({a[31:4], m0, 1'b0, 1'b1, rw, id});
        sb.push_back({e[31:4], m1, 1'b1, 1'b1, rw, id});
      end
      send_op(a, e, rw, id, 1);
      req_ready = 1'($urandom);
    end
    drain("b2b");
  endtask

  initial begin
    test_reset();
    test_aligned();
    test_split();
    test_backpressure();
    test_nomem_err();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_line_split.md
Name: mem_line_split

Overview:
- Sits directly downstream of the register-read/address-generation stage, on each of its two memory address paths.
- Consumes one memory operand per instruction: start address, inclusive end address, rw code and ptcid. Converts it into one or two cache-line-aligned requests with byte masks for the memory/TLB stage.
- Holds the operand across a valid/ready handshake and back-pressures upstream while a split access is in flight.

Parameters:
- LINE_LOG2, 4, log2 of line size in bytes (16-byte lines; req_bytemask width is 2**LINE_LOG2).
- ID_WIDTH, 7, width of the pass-through ptcid tag.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  synchronous active-high reset.
- in_valid  input  1  upstream operand valid.
- in_ready  output  1  block can accept an operand this cycle.
- in_addr  input  32  first byte address of access.
- in_addr_end  input  32  last byte address of access (inclusive).
- in_rw  input  2  memory rw code; 2'b00 = no memory use.
- in_ptcid  input  ID_WIDTH  instruction tag.
- req_valid  output  1  line request valid.
- req_ready  input  1  downstream accepts the request.
- req_line  output  32-LINE_LOG2  line address (addr >> LINE_LOG2).
- req_bytemask  output  2**LINE_LOG2  bytes touched within the line.
- req_rw  output  2  copy of in_rw.
- req_ptcid  output  ID_WIDTH  copy of in_ptcid.
- req_last  output  1  this is the final request of the operand.
- req_split  output  1  operand spans two lines (same on both requests).
- span_err  output  1  one-cycle pulse: operand spans more than two lines.

Behaviour:
- Reset (clr=1 at edge): state IDLE; req_valid=0, req_last=0, req_split=0, span_err=0, req_line=0, req_bytemask=0, req_rw=0, req_ptcid=0. clr overrides everything, including mid-split; a pending second request is discarded.
- States are IDLE, REQ0 and REQ1. in_ready = (state==IDLE), combinational from state only.
- Accept occurs when in_valid & in_ready. Derived values:
  - L0 = in_addr>>LINE_LOG2, L1 = in_addr_end>>LINE_LOG2, lines = (L1 - L0) mod 2**(32-LINE_LOG2).
  - so = in_addr low bits, eo = in_addr_end low bits.
- Accept with in_rw==00: no request, no error; stay IDLE.
- Accept with lines==0: go to REQ0. req_line=L0, req_bytemask bits so..eo set, req_last=1, req_split=0.
- Accept with lines==1: go to REQ0. req_line=L0, mask bits so..15, req_last=0, req_split=1. Latch L1 and eo for the second request.
- Accept with lines>=2 (including end<start beyond one-line wrap): span_err=1 for exactly the next cycle; no request; stay IDLE.
- Latency: the request is registered, so req_valid=1 in the cycle after accept.
- REQ0:
  - If req_ready=0, hold all req_* stable.
  - If req_ready=1 and req_last=1, go to IDLE with req_valid=0 next cycle.
  - If req_ready=1 and req_last=0, go to REQ1. Next cycle: req_line=L1, mask bits 0..eo, req_last=1, req_split=1; rw and ptcid unchanged.
- REQ1: hold until req_ready=1, then go to IDLE.
- Line address wrap: L0 = all-ones with L1 = 0 counts as lines==1; the second request has req_line=0.
- Throughput: at most one operand per 2 cycles unsplit, per 3 cycles split (one IDLE cycle between operands).
- req_* outputs are only meaningful when req_valid=1. The bench checks them only then.

Test Plan:
- Aligned dword: in_addr=0x00001004, end=0x00001007, rw=01, ptcid=0x05, req_ready=1. One request next cycle: line=0x0000100, mask=0x00F0, last=1, split=0, ptcid=0x05. Then IDLE and in_ready=1.
- Split qword: addr=0x0000200C, end=0x00002013, rw=10. First request: line=0x0000200, mask=0xF000, last=0. Second request: line=0x0000201, mask=0x000F, last=1. split=1 on both.
- Back-pressure: the split qword case with req_ready=0 for 3 cycles on each request. req_* held stable, in_ready=0 throughout, each request accepted exactly once.
- No-memory and error: rw=00 produces no req_valid and in_ready stays 1. addr=0x100, end=0x12F, rw=01 gives a span_err pulse of one cycle and no request.
- Wrap: addr=0xFFFFFFFE, end=0x00000001. Requests: line=0xFFFFFFF mask=0xC000, then line=0x0000000 mask=0x0003.
- Reset mid-split: clr asserted during REQ1 stall. Next cycle req_valid=0, in_ready=1, and no stale second request appears afterwards.
